p_s_serializer: RTL and testbench

//   Parallel-to-serial stage that feeds the serial input of the serial/parallel converter.

---
 rtl/p_s_serializer.sv | 155 +++++++++++++++
 tb/tb_p_s_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/p_s_serializer.sv
// p_s_serializer: parallel-to-serial stage with valid/ready on both sides.
// Each accepted WIDTH-bit word is emitted one bit per beat, either MSB-first
// or LSB-first. A one-word pending buffer lets frames stream back-to-back.
// Optional feature macro: P_S_SERIALIZER_PARITY_EN appends an even-parity
// beat (^word) after the data bits, making each frame WIDTH+1 beats long.
module p_s_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_msb_first,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_sof,
    output logic             ser_eof,
    output logic             busy
);

`ifdef P_S_SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    // Sized so the reload value FRAME_LEN always fits.
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sh_reg;
    logic               msb_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   pend_reg;
    logic               pend_msb_reg;
    logic               pend_v_reg;
`ifdef P_S_SERIALIZER_PARITY_EN
    logic               par_reg;
`endif

    logic               accept;
    logic               beat;
    logic               last_beat;
    logic               load_pend;
    logic               load_in;
    logic               to_pend;
    logic               data_bit;
    logic [WIDTH-1:0]   sh_left;
    logic [WIDTH-1:0]   sh_right;

    // Zero-filled shift toward either output end.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi == 0) begin : g_lo
            assign sh_left[gi]  = 1'b0;
            assign sh_right[gi] = sh_reg[gi+1];
        end else if (gi == WIDTH - 1) begin : g_hi
            assign sh_left[gi]  = sh_reg[gi-1];
            assign sh_right[gi] = 1'b0;
        end else begin : g_mid
            assign sh_left[gi]  = sh_reg[gi-1];
            assign sh_right[gi] = sh_reg[gi+1];
        end
    end

    assign in_ready  = !pend_v_reg;
    assign ser_valid = (state_reg == SHIFT);
    assign busy      = (state_reg == SHIFT) | pend_v_reg;
    assign ser_sof   = ser_valid & (cnt_reg == CNT_W'(FRAME_LEN));
    assign ser_eof   = ser_valid & (cnt_reg == CNT_W'(1));

    assign accept    = in_valid & in_ready;
    assign beat      = ser_valid & ser_ready;
    assign last_beat = beat & (cnt_reg == CNT_W'(1));
    // The shifter is refilled from pend first; a direct load happens when idle
    // or on a last beat with pend empty. Both cannot coincide since in_ready=0
    // while pend is full.
    assign load_pend = last_beat & pend_v_reg;
    assign load_in   = accept & ((state_reg == IDLE) | (last_beat & !pend_v_reg));
    assign to_pend   = accept & (state_reg == SHIFT) & !last_beat;

`ifdef P_S_SERIALIZER_PARITY_EN
    assign data_bit = (cnt_reg == CNT_W'(1)) ? par_reg
                    : (msb_reg ? sh_reg[WIDTH-1] : sh_reg[0]);
`else
    assign data_bit = msb_reg ? sh_reg[WIDTH-1] : sh_reg[0];
`endif
    assign ser_data = ser_valid & data_bit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: enter SHIFT on accept, leave only when the last beat has no successor.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_beat && !pend_v_reg && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shifter, bit order, beat counter and parity: load a new word or advance one beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_reg  <= '0;
            msb_reg <= 1'b0;
            cnt_reg <= '0;
`ifdef P_S_SERIALIZER_PARITY_EN
            par_reg <= 1'b0;
`endif
        end else if (load_pend) begin
            sh_reg  <= pend_reg;
            msb_reg <= pend_msb_reg;
            cnt_reg <= CNT_W'(FRAME_LEN);
`ifdef P_S_SERIALIZER_PARITY_EN
            par_reg <= ^pend_reg;
`endif
        end else if (load_in) begin
            sh_reg  <= in_data;
            msb_reg <= in_msb_first;
            cnt_reg <= CNT_W'(FRAME_LEN);
`ifdef P_S_SERIALIZER_PARITY_EN
            par_reg <= ^in_data;
`endif
        end else if (beat) begin
            sh_reg  <= msb_reg ? sh_left : sh_right;
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // Pending buffer: filled by accepts during a frame, drained on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg     <= '0;
            pend_msb_reg <= 1'b0;
            pend_v_reg   <= 1'b0;
        end else if (load_pend) begin
            pend_v_reg   <= 1'b0;
        end else if (to_pend) begin
            pend_reg     <= in_data;
            pend_msb_reg <= in_msb_first;
            pend_v_reg   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_p_s_serializer.sv
// tb_p_s_serializer: randomized and directed checks of p_s_serializer against
// a queue-of-beats reference model. Honors P_S_SERIALIZER_PARITY_EN.
module tb_p_s_serializer;

    localparam int W = 4;
`ifdef P_S_SERIALIZER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_msb_first;
    logic         in_valid;
    logic         in_ready;
    logic         ser_data;
    logic         ser_valid;
    logic         ser_ready;
    logic         ser_sof;
    logic         ser_eof;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Model: every outstanding beat as {sof, eof, data}, oldest first.
    logic [2:0] exp_q[$];
    // Beats the DUT actually handed over, {sof, eof, data}.
    logic [2:0] log_q[$];

    p_s_serializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_msb_first (in_msb_first),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ser_data     (ser_data),
        .ser_valid    (ser_valid),
        .ser_ready    (ser_ready),
        .ser_sof      (ser_sof),
        .ser_eof      (ser_eof),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int words_out();
        return (exp_q.size() + FL - 1) / FL;
    endfunction

    // Expand a word into its beats in transmit order.
    task automatic push_frame(input logic [W-1:0] w, input logic m);
        for (int i = 0; i < W; i++) begin
            logic b;
            b = m ? w[W-1-i] : w[i];
            exp_q.push_back({(i == 0), (i == FL - 1), b});
        end
`ifdef P_S_SERIALIZER_PARITY_EN
        exp_q.push_back({1'b0, 1'b1, ^w});
`endif
    endtask

    task automatic check_outputs();
        chk("ser_valid", ser_valid, exp_q.size() > 0);
        chk("in_ready", in_ready, words_out() < 2);
        chk("busy", busy, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("ser_data", ser_data, exp_q[0][0]);
            chk("ser_sof", ser_sof, exp_q[0][2]);
            chk("ser_eof", ser_eof, exp_q[0][1]);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic m, input logic r,
                         output logic acc);
        logic pop;
        in_valid     = v;
        in_data      = d;
        in_msb_first = m;
        ser_ready    = r;
        acc = v && (words_out() < 2);
        pop = (exp_q.size() > 0) && r;
        if (pop && ser_valid) log_q.push_back({ser_sof, ser_eof, ser_data});
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            push_frame(d, m);
            $display("accept word=%h msb_first=%0d t=%0t", d, m, $time);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Compare the logged single frame with a constant bit pattern (first beat = bit n-1).
    task automatic chk_log(input string tag, input logic [15:0] bits, input int n);
        chk({tag, "_len"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            chk({tag, "_data"}, log_q[i][0], bits[n-1-i]);
            chk({tag, "_sof"}, log_q[i][2], (i == 0));
            chk({tag, "_eof"}, log_q[i][1], (i == n - 1));
        end
        log_q.delete();
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic m);
        logic acc;
        cycle(1'b1, d, m, 1'b1, acc);
        chk("direct_accept", acc, 1'b1);
        for (int i = 0; i < FL + 1; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        int   guard;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; ser_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sof_eof_data", {ser_sof, ser_eof, ser_data}, 3'b000);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);

        // Single words, both bit orders.
        log_q.delete();
        send_word(4'b1011, 1'b1);
`ifdef P_S_SERIALIZER_PARITY_EN
        chk_log("msb_1011", 16'b10111, 5);
`else
        chk_log("msb_1011", 16'b1011, 4);
`endif
        send_word(4'b1011, 1'b0);
`ifdef P_S_SERIALIZER_PARITY_EN
        chk_log("lsb_1011", 16'b11011, 5);
`else
        chk_log("lsb_1011", 16'b1101, 4);
`endif
        send_word(4'b0111, 1'b1);
`ifdef P_S_SERIALIZER_PARITY_EN
        chk_log("msb_0111", 16'b01111, 5);
`else
        chk_log("msb_0111", 16'b0111, 4);
`endif

        // Back-to-back 4'hA then 4'h5 with in_valid held until each is taken.
        guard = 0;
        do begin cycle(1'b1, 4'hA, 1'b1, 1'b1, acc); guard++; end while (!acc && guard < 20);
        chk("b2b_a_accepted", acc, 1'b1);
        guard = 0;
        do begin cycle(1'b1, 4'h5, 1'b1, 1'b1, acc); guard++; end while (!acc && guard < 20);
        chk("b2b_5_accepted", acc, 1'b1);
        for (int i = 0; i < 2 * FL + 2; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
        chk("b2b_len", log_q.size(), 2 * FL);
        begin
            logic [15:0] b2b;
`ifdef P_S_SERIALIZER_PARITY_EN
            b2b = 16'b1010_0_0101_0;
`else
            b2b = 16'b1010_0101;
`endif
            for (int i = 0; i < 2 * FL && i < log_q.size(); i++)
                chk("b2b_data", log_q[i][0], b2b[2*FL-1-i]);
        end
        log_q.delete();

        // Backpressure for 3 cycles mid-frame.
        cycle(1'b1, 4'b1001, 1'b1, 1'b1, acc);
        cycle(1'b0, '0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, acc);
        for (int i = 0; i < FL + 1; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
`ifdef P_S_SERIALIZER_PARITY_EN
        chk_log("bp_1001", 16'b10010, 5);
`else
        chk_log("bp_1001", 16'b1001, 4);
`endif

        // Reset asserted on beat 2 of 4'hF.
        cycle(1'b1, 4'hF, 1'b1, 1'b1, acc);
        cycle(1'b0, '0, 1'b0, 1'b1, acc);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_ser_valid", ser_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_sof_eof_data", {ser_sof, ser_eof, ser_data}, 3'b000);
        exp_q.delete();
        log_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
        chk("midrst_no_tail", log_q.size(), 0);
        send_word(4'h3, 1'b1);
`ifdef P_S_SERIALIZER_PARITY_EN
        chk_log("after_rst_3", 16'b00110, 5);
`else
        chk_log("after_rst_3", 16'b0011, 4);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 3) != 0), W'($urandom), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) != 0), acc);
        end
        // Drain.
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            cycle(1'b0, '0, 1'b0, 1'b1, acc);
            guard++;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
